// File: rtl/flash_jtag_frame_builder.sv
// Serializes five 288-bit Buckeye patterns into the 432-byte {00,TDI[5:1],TMS}
// JTAG frame and hands it byte-by-byte to the flash loader over a 4-phase REQ/ACK.

module flash_jtag_frame_builder_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [15:0] word_i,
  output logic        bit_o
);
  logic [15:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr_q <= '0;
    else if (load_i)  sr_q <= word_i;
    else if (shift_i) sr_q <= {1'b0, sr_q[15:1]};
  end

  assign bit_o = sr_q[0];
endmodule

module flash_jtag_frame_builder #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        FASTCLK,
  input  logic        RST_B,
  input  logic        WR_EN,
  input  logic [6:0]  WR_ADR,
  input  logic [15:0] WR_DATA,
  input  logic        START,
  input  logic        ABORT,
  output logic        LD_REQ,
  output logic [7:0]  LD_DATA,
  input  logic        LD_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [8:0]  BYTE_CNT
);
  localparam int NUM_LANES = 5;
  localparam int DEPTH     = 90;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_RELEASE, S_FINISH} state_e;

  state_e                 state_q, state_d;
  logic [8:0]             cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic [7:0]             data_q, data_d;
  logic                   err_q, err_d;
  logic [9:0]             tmr_q, tmr_d;
  logic [2:0]             fidx_q, fidx_d;
  logic                   shift;
  logic [NUM_LANES-1:0]   ld_lane;
  logic [NUM_LANES-1:0]   lane_bit;
  logic [15:0]            mem_q [0:DEPTH-1];

  logic       busy, in_data, need_fetch, tmr_exp, viol, tms;
  logic [8:0] cnt_m3, cnt_nx, nx_m3;
  logic [6:0] rd_adr;
  logic [7:0] frame_byte;

  assign busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign viol    = busy && (WR_EN || START);
  assign tmr_exp = (tmr_q == 10'(ACK_TIMEOUT - 1));

  // Data region covers bytes 3..290; fetch on every 16th data byte.
  assign in_data    = (cnt_q >= 9'd3) && (cnt_q <= 9'd290);
  assign cnt_m3     = cnt_q - 9'd3;
  assign cnt_nx     = cnt_q + 9'd1;
  assign nx_m3      = cnt_nx - 9'd3;
  assign need_fetch = (cnt_nx >= 9'd3) && (cnt_nx <= 9'd290) && (nx_m3[3:0] == 4'd0);
  assign rd_adr     = 7'(fidx_q) * 7'd18 + {2'b00, cnt_m3[8:4]};

  assign tms        = (cnt_q == 9'd0) || (cnt_q == 9'd290) || (cnt_q == 9'd291);
  assign frame_byte = {2'b00, (in_data ? lane_bit : '0), tms};

  // Pattern store is deliberately left unreset.
  always_ff @(posedge FASTCLK) begin
    if (WR_EN && !busy && (WR_ADR < 7'(DEPTH))) mem_q[WR_ADR] <= WR_DATA;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    flash_jtag_frame_builder_lane u_lane (
      .clk     (FASTCLK),
      .rst_n   (RST_B),
      .load_i  (ld_lane[g]),
      .shift_i (shift),
      .word_i  (mem_q[rd_adr]),
      .bit_o   (lane_bit[g])
    );
  end

  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      fidx_q  <= fidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q | viol;
    tmr_d   = tmr_q;
    fidx_d  = fidx_q;
    shift   = 1'b0;
    ld_lane = '0;
    case (state_q)
      S_IDLE: if (START) begin
        err_d   = 1'b0;
        cnt_d   = '0;
        data_d  = 8'h01;
        req_d   = 1'b1;
        tmr_d   = '0;
        state_d = S_EMIT;
      end
      S_FETCH: begin
        ld_lane[fidx_q] = 1'b1;
        fidx_d = fidx_q + 3'd1;
        if (fidx_q == 3'(NUM_LANES - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = frame_byte;
        req_d   = 1'b1;
        tmr_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (LD_ACK) begin
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = S_RELEASE;
        end else if (tmr_exp) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q + 10'd1;
      end
      S_RELEASE: begin
        if (!LD_ACK) begin
          shift = in_data;
          if (cnt_q == 9'd431) state_d = S_FINISH;
          else begin
            cnt_d = cnt_nx;
            if (need_fetch) begin
              fidx_d  = '0;
              state_d = S_FETCH;
            end else state_d = S_LOAD;
          end
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q + 10'd1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous START.
    if (ABORT) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q | viol;
      shift   = 1'b0;
      ld_lane = '0;
    end
  end

  assign LD_REQ   = req_q;
  assign LD_DATA  = data_q;
  assign BUSY     = busy;
  assign DONE     = (state_q == S_FINISH);
  assign ERR      = err_q;
  assign BYTE_CNT = cnt_q;
endmodule
